// File: rtl/mdu_ctrl_if.sv
// Bundle of the E-stage command, D-stage hazard hint and HI/LO result
// signals shared between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    // Pipeline side: issues commands, observes results and the stall request.
    modport master (
        output md_op, start, a, b, d_is_md,
        input  hi, lo, busy, stall
    );

    // Unit side: accepts commands, owns HI/LO, busy and stall.
    modport slave (
        input  md_op, start, a, b, d_is_md,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, models the
// fixed mult/div latency with a down-counter and raises the D-stage stall
// that holds any following HI/LO instruction until results are in place.
module mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    md_op_e           op;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             wr_pending_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res_hi_q;
    logic [31:0]      res_lo_q;

    logic             issue;
    logic             is_mul;
    logic             is_div;
    logic             is_long;
    logic             b_zero;

    logic [63:0]      product;
    logic [31:0]      quot;
    logic [31:0]      rem;

    assign op = md_op_e'(bus.md_op);

    // Command decode; a start seen while busy is a protocol violation and
    // is dropped because issue requires the unit to be idle.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first,
        // otherwise synthesis would infer a latch to hold the old value.
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV,  OP_DIVU:  is_div = 1'b1;
            default:           ;
        endcase
        is_long = is_mul | is_div;
        issue   = bus.start & ~busy_q;
        b_zero  = (bus.b == 32'd0);
    end

    // 64-bit product: the low 64 bits of a product of sign-extended operands
    // equal the signed product, so one multiplier serves mult and multu.
    always_comb begin
        logic        mul_signed;
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        mul_signed = (op == OP_MULT);
        a_ext      = {{32{mul_signed & bus.a[31]}}, bus.a};
        b_ext      = {{32{mul_signed & bus.b[31]}}, bus.b};
        product    = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder takes the dividend's sign. Working on
    // magnitudes makes 0x80000000 / -1 wrap to 0x80000000 without overflow.
    always_comb begin
        logic        div_signed;
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] divisor;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & bus.a[31];
        b_neg      = div_signed & bus.b[31];
        a_mag      = a_neg ? (~bus.a + 32'd1) : bus.a;
        b_mag      = b_neg ? (~bus.b + 32'd1) : bus.b;
        // A zero divisor never commits a result; substitute 1 to keep the
        // arithmetic defined.
        divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Result latch captured at issue and held until the final countdown edge.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the staged result is only ever
        // consumed under wr_pending, which is reset, so stale data is harmless.
        if (issue && is_mul) begin
            res_hi_q <= product[63:32];
            res_lo_q <= product[31:0];
        end else if (issue && is_div) begin
            res_hi_q <= rem;
            res_lo_q <= quot;
        end
    end

    // Sequencer: reset, countdown with final HI/LO commit, or command issue.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, matching real flip-flops.
        if (reset) begin
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            wr_pending_q <= 1'b0;
        end else if (busy_q) begin
            cnt_q  <= cnt_q - CNT_ONE;
            busy_q <= (cnt_q != CNT_ONE);
            if (cnt_q == CNT_ONE) begin
                if (wr_pending_q) begin
                    hi_q <= res_hi_q;
                    lo_q <= res_lo_q;
                end
                wr_pending_q <= 1'b0;
            end
        end else if (issue) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    cnt_q        <= MULT_LOAD;
                    busy_q       <= 1'b1;
                    wr_pending_q <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    // Divide-by-zero still occupies the unit but leaves
                    // HI/LO untouched.
                    cnt_q        <= DIV_LOAD;
                    busy_q       <= 1'b1;
                    wr_pending_q <= ~b_zero;
                end
                OP_MTHI: hi_q <= bus.a;
                OP_MTLO: lo_q <= bus.a;
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    // Hold a D-stage HI/LO instruction while a long op is in flight or is
    // being issued this very cycle; mthi/mtlo complete at the issue edge.
    assign bus.stall = bus.d_is_md & (busy_q | (bus.start & is_long));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand sequences
// for stall/reset corners, and random traffic against a cycle-indexed model.
module tb_mdu_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic clk;
    logic reset;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;
    int cyc;

    // Reference model: architectural HI/LO plus the absolute cycle index at
    // which the unit becomes free again and the result pending for it.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    int          done_cyc;
    bit          pend;
    logic        last_stall;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model reaction to the coming clock edge.
    task automatic model_edge(input logic rst_v, input logic [2:0] op, input logic st,
                              input logic [31:0] av, input logic [31:0] bv);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        bit              busy_now;
        busy_now = (cyc < done_cyc);
        if (rst_v) begin
            m_hi = 0; m_lo = 0; pend = 0; done_cyc = 0;
        end else if (busy_now) begin
            if (cyc + 1 == done_cyc && pend) begin
                m_hi = p_hi; m_lo = p_lo; pend = 0;
            end
        end else if (st) begin
            case (op)
                3'd1: begin
                    sp = longint'($signed(av)) * longint'($signed(bv));
                    p_hi = sp[63:32]; p_lo = sp[31:0];
                    pend = 1; done_cyc = cyc + 1 + MULT_CYC;
                end
                3'd2: begin
                    up = {32'h0, av} * {32'h0, bv};
                    p_hi = up[63:32]; p_lo = up[31:0];
                    pend = 1; done_cyc = cyc + 1 + MULT_CYC;
                end
                3'd3, 3'd4: begin
                    done_cyc = cyc + 1 + DIV_CYC;
                    if (bv == 0) begin
                        pend = 0;
                    end else begin
                        if (op == 3'd3) begin
                            sa = longint'($signed(av)); sb = longint'($signed(bv));
                        end else begin
                            sa = longint'({32'h0, av}); sb = longint'({32'h0, bv});
                        end
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                        pend = 1;
                    end
                end
                3'd5: m_hi = av;
                3'd6: m_lo = av;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs mid-cycle, advance.
    task automatic cycle(input logic rst_v, input logic [2:0] op, input logic st,
                         input logic [31:0] av, input logic [31:0] bv, input logic dmd);
        logic eb;
        logic es;
        reset = rst_v; bus.md_op = op; bus.start = st;
        bus.a = av; bus.b = bv; bus.d_is_md = dmd;
        #2;
        eb = (cyc < done_cyc);
        es = dmd & (eb | (st & (op >= 3'd1) & (op <= 3'd4)));
        check("busy", {31'b0, bus.busy}, {31'b0, eb});
        check("stall", {31'b0, bus.stall}, {31'b0, es});
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
        last_stall = bus.stall;
        model_edge(rst_v, op, st, av, bv);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic dmd);
        cycle(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, dmd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n;
    int stall_cnt;

    initial begin
        total = 0; bad = 0; cyc = 0;
        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{3'd3, 32'h00012345, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[9]  = '{3'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'h0FFFFFFF, 0};
        vecs[10] = '{3'd6, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[12] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[13] = '{3'd7, 32'hDEADBEEF, 32'h00000003, 32'hFFFFFFFE, 32'h00000001, 0};

        // Initial reset, unchecked while DUT state is still unknown.
        reset = 1'b1; bus.md_op = 3'd0; bus.start = 1'b0;
        bus.a = 32'h0; bus.b = 32'h0; bus.d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; pend = 0; done_cyc = 0; cyc = 0;

        // Idle after reset: everything stays zero.
        repeat (3) idle(1'b0);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, vecs[i].op, 1'b1, vecs[i].a, vecs[i].b, 1'b0);
            n = 0;
            while (bus.busy === 1'b1 && n < 40) begin
                idle(1'b0);
                n++;
            end
            check($sformatf("v%0d busy_cycles", i), n, vecs[i].cyc);
            check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
            check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
        end

        // Stall window with d_is_md held high from the mult issue cycle.
        cycle(1'b0, 3'd1, 1'b1, 32'd3, 32'd4, 1'b1);
        stall_cnt = last_stall ? 1 : 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            idle(1'b1);
            stall_cnt += last_stall ? 1 : 0;
            n++;
        end
        check("stall_total", stall_cnt, 6);
        idle(1'b1);
        check("stall_after_busy", {31'b0, last_stall}, 32'd0);
        check("mult_3x4_lo", bus.lo, 32'd12);

        // Same op with no HI/LO instruction in D: never stalls.
        cycle(1'b0, 3'd2, 1'b1, 32'd5, 32'd6, 1'b0);
        stall_cnt = last_stall ? 1 : 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            idle(1'b0);
            stall_cnt += last_stall ? 1 : 0;
            n++;
        end
        check("stall_no_dmd", stall_cnt, 0);

        // Back-to-back mthi/mtlo: write at their own edge, no busy, no stall.
        cycle(1'b0, 3'd5, 1'b1, 32'h12345678, 32'h0, 1'b1);
        check("mthi_stall", {31'b0, last_stall}, 32'd0);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_busy", {31'b0, bus.busy}, 32'd0);
        cycle(1'b0, 3'd6, 1'b1, 32'h9ABCDEF0, 32'h0, 1'b1);
        check("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        check("mtlo_hi_kept", bus.hi, 32'h12345678);
        check("mtlo_busy", {31'b0, bus.busy}, 32'd0);

        // Reset during busy cycle 4 of a divide: result must never land.
        cycle(1'b0, 3'd3, 1'b1, 32'd100, 32'd7, 1'b0);
        repeat (3) idle(1'b0);
        cycle(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        repeat (12) idle(1'b0);
        check("rst_mid_late_hi", bus.hi, 32'd0);
        check("rst_mid_late_lo", bus.lo, 32'd0);

        // Reset coinciding with the final countdown edge: no write either.
        cycle(1'b0, 3'd5, 1'b1, 32'h55, 32'h0, 1'b0);
        cycle(1'b0, 3'd3, 1'b1, 32'd100, 32'd7, 1'b0);
        repeat (DIV_CYC - 1) idle(1'b0);
        check("rst_final_busy_before", {31'b0, bus.busy}, 32'd1);
        cycle(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rst_final_hi", bus.hi, 32'd0);
        check("rst_final_lo", bus.lo, 32'd0);
        repeat (3) idle(1'b0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic [2:0]  r_op;
            logic        r_st;
            logic [31:0] r_a;
            logic [31:0] r_b;
            logic        r_dmd;
            r_rst = ($urandom_range(0, 63) == 0);
            r_op  = 3'($urandom_range(0, 7));
            r_st  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       r_a = 32'h80000000;
                1:       r_a = 32'hFFFFFFFF;
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       r_b = 32'h0;
                1:       r_b = 32'hFFFFFFFF;
                2:       r_b = 32'($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            r_dmd = $urandom_range(0, 1) != 0;
            cycle(r_rst, r_op, r_st, r_a, r_b, r_dmd);
        end
        repeat (DIV_CYC + 2) idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
